sync_fifo_small: RTL and testbench

- Shallow synchronous FIFO with full/empty handshake flags. It is used as a pipeline buffer between producer and consumer logic, such as write-side capture buffers and combined result buffers.
- One module covers both FIFO1 (single-entry) and FIFO2 (two-entry) behaviour, selected by a parameter.
- Data out is the registered head entry, so consumers read D_OUT combinationally whenever EMPTY_N=1.

---
 rtl/sync_fifo_small.sv | 121 ++++++++++++
 tb/tb_sync_fifo_small.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_small.sv
// ============================================================================
//  Module   : sync_fifo_small
//  Brief    : Shallow synchronous FIFO (1 or 2 entries) with registered
//             FULL_N / EMPTY_N handshake flags and a registered head output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_small #(
   parameter int width = 8,
   parameter int depth = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [width-1:0] D_IN,
   input  logic             ENQ,
   input  logic             DEQ,
   input  logic             CLR,
   output logic [width-1:0] D_OUT,
   output logic             FULL_N,
   output logic             EMPTY_N
);

   logic [width-1:0] r_data0;
   logic             r_full_n;
   logic             r_empty_n;
   logic             w_enq;
   logic             w_deq;

   assign w_enq   = ENQ & r_full_n;
   assign w_deq   = DEQ & r_empty_n;
   assign D_OUT   = r_data0;
   assign FULL_N  = r_full_n;
   assign EMPTY_N = r_empty_n;

   generate
      if ((width < 1) || (width > 64)) begin : g_bad_width
         $error("sync_fifo_small: width must be in 1..64");
      end

      if (depth == 1) begin : g_depth1
         // Enq needs empty and deq needs full, so at most one is ever effective.
         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               r_data0   <= '0;
               r_full_n  <= 1'b1;
               r_empty_n <= 1'b0;
            end else if (CLR) begin
               r_full_n  <= 1'b1;
               r_empty_n <= 1'b0;
            end else if (w_enq) begin
               r_data0   <= D_IN;
               r_full_n  <= 1'b0;
               r_empty_n <= 1'b1;
            end else if (w_deq) begin
               r_full_n  <= 1'b1;
               r_empty_n <= 1'b0;
            end
         end
      end else if (depth == 2) begin : g_depth2
         logic [1:0]       r_count;
         logic [1:0]       w_count_nxt;
         logic [width-1:0] r_data1;

         always_comb begin
            w_count_nxt = r_count;
            if (w_enq && !w_deq) begin
               w_count_nxt = r_count + 2'd1;
            end else if (w_deq && !w_enq) begin
               w_count_nxt = r_count - 2'd1;
            end
         end

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               r_count   <= 2'd0;
               r_data0   <= '0;
               r_data1   <= '0;
               r_full_n  <= 1'b1;
               r_empty_n <= 1'b0;
            end else if (CLR) begin
               r_count   <= 2'd0;
               r_full_n  <= 1'b1;
               r_empty_n <= 1'b0;
            end else begin
               r_count   <= w_count_nxt;
               r_full_n  <= (w_count_nxt != 2'd2);
               r_empty_n <= (w_count_nxt != 2'd0);
               // Head reloads from D_IN when empty or on enq+deq at one entry,
               // and shifts from the tail when a full FIFO is dequeued.
               if (w_enq && ((r_count == 2'd0) || w_deq)) begin
                  r_data0 <= D_IN;
               end else if (w_deq && (r_count == 2'd2)) begin
                  r_data0 <= r_data1;
               end
               if (w_enq && !w_deq && (r_count == 2'd1)) begin
                  r_data1 <= D_IN;
               end
            end
         end
      end else begin : g_bad_depth
         $error("sync_fifo_small: depth must be 1 or 2");
      end
   endgenerate

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      if (RST_N && !CLR) begin
         if (ENQ && !r_full_n) begin
            $warning("%m: ENQ while full ignored");
         end
         if (DEQ && !r_empty_n) begin
            $warning("%m: DEQ while empty ignored");
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_small.sv
// ============================================================================
//  Module   : tb_sync_fifo_small
//  Brief    : Checks a 2-entry and a 1-entry sync_fifo_small against queue
//             models, with directed cases followed by random traffic.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_small;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [7:0] d_in2, d_in1;
   logic       enq2, deq2, clr2;
   logic       enq1, deq1, clr1;
   logic [7:0] d_out2, d_out1;
   logic       full_n2, empty_n2, full_n1, empty_n1;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q2[$];
   logic [7:0] q1[$];
   bit         zero2, zero1;

   always #5 CLK = ~CLK;

   sync_fifo_small #(.width(8), .depth(2)) u_fifo2 (
      .CLK(CLK), .RST_N(RST_N), .D_IN(d_in2), .ENQ(enq2), .DEQ(deq2),
      .CLR(clr2), .D_OUT(d_out2), .FULL_N(full_n2), .EMPTY_N(empty_n2)
   );

   sync_fifo_small #(.width(8), .depth(1)) u_fifo1 (
      .CLK(CLK), .RST_N(RST_N), .D_IN(d_in1), .ENQ(enq1), .DEQ(deq1),
      .CLR(clr1), .D_OUT(d_out1), .FULL_N(full_n1), .EMPTY_N(empty_n1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit e, d;
      if (!RST_N) begin
         q2.delete(); q1.delete(); zero2 = 1; zero1 = 1;
      end else begin
         if (clr2) begin
            q2.delete(); zero2 = 0;
         end else begin
            e = enq2 && (q2.size() < 2);
            d = deq2 && (q2.size() > 0);
            if (d) void'(q2.pop_front());
            if (e) begin q2.push_back(d_in2); zero2 = 0; end
         end
         if (clr1) begin
            q1.delete(); zero1 = 0;
         end else begin
            e = enq1 && (q1.size() < 1);
            d = deq1 && (q1.size() > 0);
            if (d) void'(q1.pop_front());
            if (e) begin q1.push_back(d_in1); zero1 = 0; end
         end
      end
   endtask

   task automatic compare_all();
      chk("f2_full_n",  {63'd0, full_n2},  {63'd0, q2.size() < 2});
      chk("f2_empty_n", {63'd0, empty_n2}, {63'd0, q2.size() > 0});
      if (q2.size() > 0)  chk("f2_dout", {56'd0, d_out2}, {56'd0, q2[0]});
      else if (zero2)     chk("f2_dout_zero", {56'd0, d_out2}, 64'd0);
      chk("f1_full_n",  {63'd0, full_n1},  {63'd0, q1.size() < 1});
      chk("f1_empty_n", {63'd0, empty_n1}, {63'd0, q1.size() > 0});
      if (q1.size() > 0)  chk("f1_dout", {56'd0, d_out1}, {56'd0, q1[0]});
      else if (zero1)     chk("f1_dout_zero", {56'd0, d_out1}, 64'd0);
   endtask

   // Inputs are held stable across the edge; outputs sampled 1 time unit later.
   task automatic cycle();
      @(posedge CLK);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      enq2 = 0; deq2 = 0; clr2 = 0; d_in2 = 8'h00;
      enq1 = 0; deq1 = 0; clr1 = 0; d_in1 = 8'h00;
   endtask

   initial begin
      RST_N = 1'b0;
      idle_inputs();
      zero2 = 0; zero1 = 0;
      cycle();
      cycle();
      chk("rst_dout2",    {56'd0, d_out2}, 64'h00);
      chk("rst_empty_n2", {63'd0, empty_n2}, 64'd0);
      chk("rst_full_n2",  {63'd0, full_n2},  64'd1);

      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      chk("idle_empty_n2", {63'd0, empty_n2}, 64'd0);
      chk("idle_dout2",    {56'd0, d_out2}, 64'h00);

      // Fill, overflow attempt, drain
      enq2 = 1; d_in2 = 8'h11; cycle();
      d_in2 = 8'h22; cycle();
      chk("fill_full_n2", {63'd0, full_n2}, 64'd0);
      chk("fill_dout2",   {56'd0, d_out2}, 64'h11);
      d_in2 = 8'h33; cycle();
      chk("ovf_dout2",    {56'd0, d_out2}, 64'h11);
      enq2 = 0; deq2 = 1; cycle();
      chk("drain1_dout2", {56'd0, d_out2}, 64'h22);
      cycle();
      chk("drain2_empty_n2", {63'd0, empty_n2}, 64'd0);

      // Simultaneous enq+deq at one entry
      deq2 = 0; enq2 = 1; d_in2 = 8'h11; cycle();
      deq2 = 1; d_in2 = 8'h44; cycle();
      chk("ed_dout2",    {56'd0, d_out2}, 64'h44);
      chk("ed_empty_n2", {63'd0, empty_n2}, 64'd1);
      chk("ed_full_n2",  {63'd0, full_n2},  64'd1);
      enq2 = 0; deq2 = 0;

      // Single-entry behaviour
      enq1 = 1; d_in1 = 8'h5A; cycle();
      chk("d1_empty_n", {63'd0, empty_n1}, 64'd1);
      chk("d1_full_n",  {63'd0, full_n1},  64'd0);
      chk("d1_dout",    {56'd0, d_out1}, 64'h5A);
      d_in1 = 8'hA5; cycle();
      chk("d1_ovf_dout", {56'd0, d_out1}, 64'h5A);
      enq1 = 0; deq1 = 1; cycle();
      chk("d1_deq_empty_n", {63'd0, empty_n1}, 64'd0);
      chk("d1_deq_full_n",  {63'd0, full_n1},  64'd1);
      cycle();
      chk("d1_udf_empty_n", {63'd0, empty_n1}, 64'd0);
      deq1 = 0;

      // Clear while full with ENQ asserted
      enq2 = 1; d_in2 = 8'h55; cycle();
      chk("clr_pre_full_n2", {63'd0, full_n2}, 64'd0);
      clr2 = 1; d_in2 = 8'h66; cycle();
      chk("clr_empty_n2", {63'd0, empty_n2}, 64'd0);
      chk("clr_full_n2",  {63'd0, full_n2},  64'd1);
      clr2 = 0; d_in2 = 8'h77; cycle();
      chk("clr_post_dout2", {56'd0, d_out2}, 64'h77);

      // Reset mid-operation with ENQ/DEQ active
      d_in2 = 8'h88; cycle();
      RST_N = 1'b0; deq2 = 1; d_in2 = 8'h99; cycle();
      chk("mrst_empty_n2", {63'd0, empty_n2}, 64'd0);
      chk("mrst_full_n2",  {63'd0, full_n2},  64'd1);
      chk("mrst_dout2",    {56'd0, d_out2}, 64'h00);
      RST_N = 1'b1;
      idle_inputs();
      cycle();

      for (int i = 0; i < 1000; i++) begin
         enq2  = ($urandom_range(0, 99) < 55);
         deq2  = ($urandom_range(0, 99) < 50);
         clr2  = ($urandom_range(0, 99) < 2);
         d_in2 = 8'($urandom);
         enq1  = ($urandom_range(0, 99) < 50);
         deq1  = ($urandom_range(0, 99) < 50);
         clr1  = ($urandom_range(0, 99) < 2);
         d_in1 = 8'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
